id_ex_pipe_buffer: RTL and testbench

- Parametrised decode-to-execute pipeline buffer. It carries the control bundle (register-bank write enable, ALU opcode, demux select, RAM write/read) and the two register-file read operands (DR1, DR2) through STAGES register stages.
- Adds what the fixed buffer lacks: reset, per-stage valid tracking, stall (hold), flush (bubble injection) and an occupancy count.
- Sits between the control unit / register bank and the ALU / data RAM stage.

---
 rtl/id_ex_pipe_buffer_pkg.sv | 15 +
 rtl/pipe_stage_reg.sv | 45 ++++
 rtl/id_ex_pipe_buffer.sv | 94 +++++++++
 tb/tb_id_ex_pipe_buffer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_buffer_pkg.sv
// id_ex_pkg: shared control-bundle type and constants for the decode-to-execute buffer
//   ALU_OP_W : ALU opcode width carried in the control bundle
//   ctrl_t   : {we_br, op_alu, sel_dmx, w_ram, r_ram}
//   CTRL_NOP : all-zero control bundle carried by bubbles
package id_ex_pkg;
   localparam int ALU_OP_W = 4;
   typedef struct packed {
      logic                we_br;
      logic [ALU_OP_W-1:0] op_alu;
      logic                sel_dmx;
      logic                w_ram;
      logic                r_ram;
   } ctrl_t;
   localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage holding {valid, ctrl, dr1, dr2}
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   clear            : zero the stage on the next edge (beats hold and load)
//   hold             : keep current contents (beats load)
//   load             : capture the d_* bundle
//   d_valid/ctrl/dr1/dr2 : incoming bundle
//   q_valid/ctrl/dr1/dr2 : registered bundle
module pipe_stage_reg
   import id_ex_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              hold,
   input  logic              load,
   input  logic              d_valid,
   input  ctrl_t             d_ctrl,
   input  logic [DATA_W-1:0] d_dr1,
   input  logic [DATA_W-1:0] d_dr2,
   output logic              q_valid,
   output ctrl_t             q_ctrl,
   output logic [DATA_W-1:0] q_dr1,
   output logic [DATA_W-1:0] q_dr2
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_valid <= 1'b0;
         q_ctrl  <= CTRL_NOP;
         q_dr1   <= '0;
         q_dr2   <= '0;
      end else if (clear) begin
         q_valid <= 1'b0;
         q_ctrl  <= CTRL_NOP;
         q_dr1   <= '0;
         q_dr2   <= '0;
      end else if (load && !hold) begin
         q_valid <= d_valid;
         q_ctrl  <= d_ctrl;
         q_dr1   <= d_dr1;
         q_dr2   <= d_dr2;
      end
   end
endmodule

// File: rtl/id_ex_pipe_buffer.sv
// id_ex_pipe_buffer: STAGES-deep decode-to-execute buffer with valid tracking, stall, flush and occupancy
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   stall        : hold every stage, drop the input
//   flush        : invalidate and clear every stage (wins over stall)
//   in_*         : control bundle and operands from decode
//   out_*        : last-stage contents toward ALU / data RAM
//   occupancy    : number of valid stages
module id_ex_pipe_buffer
   import id_ex_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4,
   parameter int STAGES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          stall,
   input  logic                          flush,
   input  logic                          in_valid,
   input  logic                          in_we_br,
   input  logic [OP_W-1:0]               in_op_alu,
   input  logic                          in_sel_dmx,
   input  logic                          in_w_ram,
   input  logic                          in_r_ram,
   input  logic [DATA_W-1:0]             in_dr1,
   input  logic [DATA_W-1:0]             in_dr2,
   output logic                          out_valid,
   output logic                          out_we_br,
   output logic [OP_W-1:0]               out_op_alu,
   output logic                          out_sel_dmx,
   output logic                          out_w_ram,
   output logic                          out_r_ram,
   output logic [DATA_W-1:0]             out_dr1,
   output logic [DATA_W-1:0]             out_dr2,
   output logic [$clog2(STAGES+1)-1:0]   occupancy
);
   localparam int OCC_W = $clog2(STAGES+1);
   ctrl_t             in_ctrl;
   logic              d_valid [STAGES];
   ctrl_t             d_ctrl  [STAGES];
   logic [DATA_W-1:0] d_dr1   [STAGES];
   logic [DATA_W-1:0] d_dr2   [STAGES];
   logic              q_valid [STAGES];
   ctrl_t             q_ctrl  [STAGES];
   logic [DATA_W-1:0] q_dr1   [STAGES];
   logic [DATA_W-1:0] q_dr2   [STAGES];
   // bubbles enter with a zeroed control bundle so no write strobe can leak out
   assign in_ctrl = in_valid ? ctrl_t'({in_we_br, in_op_alu, in_sel_dmx, in_w_ram, in_r_ram}) : CTRL_NOP;
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign d_valid[i] = in_valid;
         assign d_ctrl[i]  = in_ctrl;
         assign d_dr1[i]   = in_dr1;
         assign d_dr2[i]   = in_dr2;
      end else begin : g_link
         assign d_valid[i] = q_valid[i-1];
         assign d_ctrl[i]  = q_ctrl[i-1];
         assign d_dr1[i]   = q_dr1[i-1];
         assign d_dr2[i]   = q_dr2[i-1];
      end
      pipe_stage_reg #(.DATA_W(DATA_W)) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .clear   (flush),
         .hold    (stall),
         .load    (1'b1),
         .d_valid (d_valid[i]),
         .d_ctrl  (d_ctrl[i]),
         .d_dr1   (d_dr1[i]),
         .d_dr2   (d_dr2[i]),
         .q_valid (q_valid[i]),
         .q_ctrl  (q_ctrl[i]),
         .q_dr1   (q_dr1[i]),
         .q_dr2   (q_dr2[i])
      );
   end
   assign out_valid   = q_valid[STAGES-1];
   assign out_we_br   = q_ctrl[STAGES-1].we_br;
   assign out_op_alu  = q_ctrl[STAGES-1].op_alu;
   assign out_sel_dmx = q_ctrl[STAGES-1].sel_dmx;
   assign out_w_ram   = q_ctrl[STAGES-1].w_ram;
   assign out_r_ram   = q_ctrl[STAGES-1].r_ram;
   assign out_dr1     = q_dr1[STAGES-1];
   assign out_dr2     = q_dr2[STAGES-1];
   // entering valid adds one, leaving valid removes one; stays within 0..STAGES
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         occupancy <= '0;
      else if (flush)
         occupancy <= '0;
      else if (!stall)
         occupancy <= occupancy + OCC_W'(in_valid) - OCC_W'(out_valid);
   end
endmodule

// File: tb/tb_id_ex_pipe_buffer.sv
// tb_id_ex_pipe_buffer: scoreboard bench driving a 2-stage and a 4-stage buffer with shared stimulus
module tb_id_ex_pipe_buffer;
   typedef struct packed {
      logic        valid;
      logic        we;
      logic [3:0]  op;
      logic        sel;
      logic        w;
      logic        r;
      logic [31:0] dr1;
      logic [31:0] dr2;
   } ent_t;
   typedef struct packed {
      ent_t       e;
      logic [3:0] occ;
   } snap_t;

   logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
   logic in_valid = 1'b0, in_we_br = 1'b0, in_sel_dmx = 1'b0, in_w_ram = 1'b0, in_r_ram = 1'b0;
   logic [3:0]  in_op_alu = '0;
   logic [31:0] in_dr1 = '0, in_dr2 = '0;
   logic        o_valid [2], o_we [2], o_sel [2], o_w [2], o_r [2];
   logic [3:0]  o_op [2];
   logic [31:0] o_dr1 [2], o_dr2 [2];
   logic [1:0]  occ2;
   logic [2:0]  occ4;
   int total = 0, bad = 0;
   int depth [2] = '{2, 4};
   ent_t  pipe  [2][$];
   snap_t exp_q [2][$];

   always #5 clk = ~clk;

   id_ex_pipe_buffer #(.DATA_W(32), .OP_W(4), .STAGES(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_we_br(in_we_br), .in_op_alu(in_op_alu), .in_sel_dmx(in_sel_dmx), .in_w_ram(in_w_ram),
      .in_r_ram(in_r_ram), .in_dr1(in_dr1), .in_dr2(in_dr2), .out_valid(o_valid[0]),
      .out_we_br(o_we[0]), .out_op_alu(o_op[0]), .out_sel_dmx(o_sel[0]), .out_w_ram(o_w[0]),
      .out_r_ram(o_r[0]), .out_dr1(o_dr1[0]), .out_dr2(o_dr2[0]), .occupancy(occ2));

   id_ex_pipe_buffer #(.DATA_W(32), .OP_W(4), .STAGES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_we_br(in_we_br), .in_op_alu(in_op_alu), .in_sel_dmx(in_sel_dmx), .in_w_ram(in_w_ram),
      .in_r_ram(in_r_ram), .in_dr1(in_dr1), .in_dr2(in_dr2), .out_valid(o_valid[1]),
      .out_we_br(o_we[1]), .out_op_alu(o_op[1]), .out_sel_dmx(o_sel[1]), .out_w_ram(o_w[1]),
      .out_r_ram(o_r[1]), .out_dr1(o_dr1[1]), .out_dr2(o_dr2[1]), .occupancy(occ4));

   function automatic ent_t mk(input logic v, we, input logic [3:0] op, input logic sel, w, r,
                               input logic [31:0] a, b);
      ent_t e;
      e = '{valid: v, we: we, op: op, sel: sel, w: w, r: r, dr1: a, dr2: b};
      return e;
   endfunction

   function automatic snap_t dut_snap(input int d);
      snap_t s;
      s.e = mk(o_valid[d], o_we[d], o_op[d], o_sel[d], o_w[d], o_r[d], o_dr1[d], o_dr2[d]);
      s.occ = (d == 0) ? {2'b00, occ2} : {1'b0, occ4};
      return s;
   endfunction

   // reference: the pipe is a list of depth slots; output is the oldest slot
   function automatic snap_t model_step(input int d, input ent_t in, input logic st, fl);
      snap_t s;
      ent_t  e;
      int    n = 0;
      e = in;
      if (!e.valid) begin
         e.we = 1'b0; e.op = '0; e.sel = 1'b0; e.w = 1'b0; e.r = 1'b0;
      end
      if (fl) begin
         foreach (pipe[d][k]) pipe[d][k] = '0;
      end else if (!st) begin
         pipe[d].push_front(e);
         void'(pipe[d].pop_back());
      end
      foreach (pipe[d][k]) if (pipe[d][k].valid) n++;
      s.e = pipe[d][pipe[d].size()-1];
      s.occ = 4'(n);
      return s;
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         pipe[d].delete();
         exp_q[d].delete();
         for (int k = 0; k < depth[d]; k++) pipe[d].push_back('0);
      end
   endfunction

   task automatic cycle(input ent_t in, input logic st, input logic fl);
      in_valid = in.valid; in_we_br = in.we; in_op_alu = in.op; in_sel_dmx = in.sel;
      in_w_ram = in.w; in_r_ram = in.r; in_dr1 = in.dr1; in_dr2 = in.dr2;
      stall = st; flush = fl;
      @(posedge clk);
      for (int d = 0; d < 2; d++) exp_q[d].push_back(model_step(d, in, st, fl));
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle('0, 1'b0, 1'b0);
   endtask

   task automatic check_zero(input string nm);
      for (int d = 0; d < 2; d++) begin
         total++;
         if (dut_snap(d) !== '0) begin
            bad++;
            $display("FAIL %s s%0d got=%h need=0", nm, depth[d], dut_snap(d));
         end
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (exp_q[d].size() > 0) begin
            snap_t e, a;
            e = exp_q[d].pop_front();
            a = dut_snap(d);
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL out_s%0d t=%0t got=%h need=%h", depth[d], $time, a, e);
            end
         end
      end
   end

   initial begin
      logic [95:0] r96;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      // single entry latency
      cycle(mk(1, 1, 4'hA, 0, 0, 0, 32'h1234_5678, 32'hCAFE_0001), 0, 0);
      idle(5);
      // back-to-back stream
      for (int i = 1; i <= 6; i++) cycle(mk(1, 0, 4'(i), 1, 0, 1, 32'(i), ~32'(i)), 0, 0);
      idle(5);
      // stall mid-stream, offered input dropped
      for (int i = 1; i <= 4; i++) cycle(mk(1, 1, 4'(i), 0, 0, 0, 32'(i), 32'(100 + i)), 0, 0);
      repeat (3) cycle(mk(1, 1, 4'hD, 0, 1, 0, 32'hDEAD, 32'hBEEF), 1, 0);
      for (int i = 5; i <= 6; i++) cycle(mk(1, 1, 4'(i), 0, 0, 0, 32'(i), 32'(100 + i)), 0, 0);
      idle(5);
      // flush with stall while full of RAM writes
      repeat (4) cycle(mk(1, 0, 4'h3, 0, 1, 0, 32'h55, 32'hAA), 0, 0);
      cycle(mk(1, 1, 4'h7, 1, 1, 1, 32'h77, 32'h88), 1, 1);
      idle(2);
      // bubbles with control bits set
      repeat (6) cycle(mk(0, 1, 4'hF, 1, 1, 1, $urandom(), $urandom()), 0, 0);
      // random traffic
      repeat (400) begin
         r96 = {$urandom(), $urandom(), $urandom()};
         cycle(ent_t'(r96[73:0]), $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4);
      end
      // async reset between edges with a full pipe
      repeat (5) begin
         r96 = {$urandom(), $urandom(), $urandom()};
         cycle(mk(1, r96[0], r96[4:1], r96[5], r96[6], r96[7], r96[39:8], r96[71:40]), 0, 0);
      end
      model_reset();
      #1 rst_n = 1'b0;
      #1 check_zero("async_rst");
      @(negedge clk) rst_n = 1'b1;
      cycle(mk(1, 1, 4'hA, 0, 0, 0, 32'h1234_5678, 32'hCAFE_0001), 0, 0);
      idle(6);
      repeat (5) cycle(mk(1, 0, 4'h1, 0, 0, 1, 32'h9, 32'h8), 0, 0);
      idle(6);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
